// File: rtl/adam_periph_uart_tx_fifo.sv
// UART transmitter with a DEPTH-entry write FIFO, frame-boundary pause handshake and a per-frame latched line format.
// Optional parity support is compiled in when ADAM_PERIPH_UART_TX_PARITY_EN is defined.
module adam_periph_uart_tx_fifo #(
    parameter int DATA_WIDTH = 9,
    parameter int DEPTH      = 8,
    parameter int BRR_WIDTH  = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pause_req,
    output logic                         pause_ack,
    input  logic                         tx_en,
    input  logic [BRR_WIDTH-1:0]         brr,
    input  logic [3:0]                   data_bits,
    input  logic                         parity_en,
    input  logic                         parity_odd,
    input  logic                         stop2,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         wvalid,
    output logic                         wready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         irq_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef ADAM_PERIPH_UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t state, state_next;

    // FIFO storage and bookkeeping
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [LW-1:0]         count;
    logic                  full, push, pop;

    // Frame datapath
    logic [BRR_WIDTH-1:0]  brr_eff, brr_q, baud_cnt;
    logic [3:0]            nbits_in, nbits_q, bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  stop2_q, stop_second;
    logic                  bit_done, last_bit, start_ok, start_frame, tx_next;

`ifdef ADAM_PERIPH_UART_TX_PARITY_EN
    logic                  par_en_q, par_odd_q, par_acc;
`else
    logic                  unused_parity_cfg;
    assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

    assign full      = (count == LW'(DEPTH));
    assign wready    = !full && !pause_ack;
    assign push      = wvalid && wready;
    assign pop       = start_frame;
    assign level     = count;
    assign busy      = (state != IDLE);
    assign irq_empty = (count == '0) && !busy;

    assign brr_eff  = (brr == '0) ? BRR_WIDTH'(1) : brr;
    assign nbits_in = (data_bits < 4'd5)              ? 4'd5 :
                      (data_bits > 4'(DATA_WIDTH))    ? 4'(DATA_WIDTH) : data_bits;

    assign bit_done = (baud_cnt == '0);
    assign last_bit = (bit_idx == nbits_q - 4'd1);
    assign start_ok = tx_en && (count != '0) && !pause_req;

    // NOTE: storage array has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        tx_next     = 1'b1;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_next  = START;
                    start_frame = 1'b1;
                end
            end
            START: begin
                tx_next = 1'b0;
                if (bit_done) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                tx_next = shreg[0];
                if (bit_done && last_bit) begin
`ifdef ADAM_PERIPH_UART_TX_PARITY_EN
                    state_next = par_en_q ? PARITY : STOP;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef ADAM_PERIPH_UART_TX_PARITY_EN
            PARITY: begin
                tx_next = par_acc ^ par_odd_q;
                if (bit_done) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done && (!stop2_q || stop_second)) begin
                    // Chain straight into the next frame when one is ready.
                    if (start_ok) begin
                        state_next  = START;
                        start_frame = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx        <= 1'b1;
            pause_ack <= 1'b0;
        end else begin
            tx        <= tx_next;
            pause_ack <= pause_req && (state == IDLE);
        end
    end

    // Line format is captured once per frame so mid-frame changes cannot corrupt it.
    always_ff @(posedge clk) begin
        if (start_frame) begin
            brr_q       <= brr_eff;
            nbits_q     <= nbits_in;
            stop2_q     <= stop2;
            shreg       <= mem[rd_ptr];
            baud_cnt    <= brr_eff - BRR_WIDTH'(1);
            bit_idx     <= '0;
            stop_second <= 1'b0;
`ifdef ADAM_PERIPH_UART_TX_PARITY_EN
            par_en_q    <= parity_en;
            par_odd_q   <= parity_odd;
            par_acc     <= 1'b0;
`endif
        end else if (state != IDLE) begin
            if (bit_done) begin
                baud_cnt <= brr_q - BRR_WIDTH'(1);
                if (state == DATA) begin
                    shreg   <= shreg >> 1;
                    bit_idx <= bit_idx + 4'd1;
`ifdef ADAM_PERIPH_UART_TX_PARITY_EN
                    par_acc <= par_acc ^ shreg[0];
`endif
                end
                if (state == STOP) begin
                    stop_second <= 1'b1;
                end
            end else begin
                baud_cnt <= baud_cnt - BRR_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_adam_periph_uart_tx_fifo.sv
// Directed self-checking bench for adam_periph_uart_tx_fifo; all outputs sampled on the falling edge.
// Parity expectations follow ADAM_PERIPH_UART_TX_PARITY_EN the same way the design does.
module tb_adam_periph_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause_req;
    logic        pause_ack;
    logic        tx_en;
    logic [31:0] brr;
    logic [3:0]  data_bits;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic [8:0]  wdata;
    logic        wvalid;
    logic        wready;
    logic        tx;
    logic        busy;
    logic [3:0]  level;
    logic        irq_empty;

    int checks = 0;
    int errors = 0;

    adam_periph_uart_tx_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .pause_req  (pause_req),
        .pause_ack  (pause_ack),
        .tx_en      (tx_en),
        .brr        (brr),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .stop2      (stop2),
        .wdata      (wdata),
        .wvalid     (wvalid),
        .wready     (wready),
        .tx         (tx),
        .busy       (busy),
        .level      (level),
        .irq_empty  (irq_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one write beat; returns on the falling edge after the accepting edge.
    task automatic push(input logic [8:0] d);
        wdata  = d;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
    endtask

    // fb holds the line bits LSB-first (start bit in bit 0); each bit is checked every cycle.
    task automatic expect_frame(input logic [15:0] fb, input int nb, input int per);
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < per; c++) begin
                check("frame_bit", tx, fb[i]);
                @(negedge clk);
            end
        end
    endtask

    task automatic single_frame(input logic [8:0] d, input logic [15:0] fb, input int nb, input int per);
        push(d);
        check("lvl_after_push", level, 1);
        @(negedge clk);
        check("tx_latency_high", tx, 1);
        check("busy_at_start", busy, 1);
        check("lvl_after_pop", level, 0);
        @(negedge clk);
        expect_frame(fb, nb, per);
        check("busy_after_frame", busy, 0);
        check("tx_idle_after_frame", tx, 1);
        check("irq_empty_after_frame", irq_empty, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        pause_req  = 1'b0;
        tx_en      = 1'b1;
        brr        = 32'd4;
        data_bits  = 4'd8;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        wdata      = '0;
        wvalid     = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_wready", wready, 1);
        check("rst_irq_empty", irq_empty, 1);
        check("rst_pause_ack", pause_ack, 0);
        rst = 1'b0;
        @(negedge clk);

        // 0xA5, 8N1, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,1
        single_frame(9'h0A5, 16'b000000_1_10100101_0, 10, 4);

        // brr=0 -> 1 cycle/bit; data_bits=3 clamps to 5; two stop bits; back-to-back frames
        brr       = 32'd0;
        data_bits = 4'd3;
        stop2     = 1'b1;
        push(9'h1F3);
        push(9'h00A);
        check("lvl_push_pop_same_edge", level, 1);
        check("busy_stop2", busy, 1);
        check("tx_latency_stop2", tx, 1);
        @(negedge clk);
        expect_frame({8'b11_01010_0, 8'b11_10011_0}, 16, 1);
        check("lvl_after_stop2", level, 0);
        check("irq_after_stop2", irq_empty, 1);
        check("tx_after_stop2", tx, 1);

        // Parity handling, 7 data bits, 1 cycle/bit
        brr       = 32'd1;
        data_bits = 4'd7;
        stop2     = 1'b0;
        parity_en = 1'b1;
`ifdef ADAM_PERIPH_UART_TX_PARITY_EN
        parity_odd = 1'b1;
        single_frame(9'h001, 16'b000000_1_0_0000001_0, 10, 1);
        parity_odd = 1'b0;
        single_frame(9'h001, 16'b000000_1_1_0000001_0, 10, 1);
        single_frame(9'h003, 16'b000000_1_0_0000011_0, 10, 1);
`else
        parity_odd = 1'b1;
        single_frame(9'h001, 16'b0000000_1_0000001_0, 9, 1);
        parity_odd = 1'b0;
        single_frame(9'h003, 16'b0000000_1_0000011_0, 9, 1);
`endif
        parity_en  = 1'b0;
        parity_odd = 1'b0;

        // Fill with transmitter disabled; ninth word must be refused
        data_bits = 4'd8;
        tx_en     = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wdata  = 9'(8'h10 + i);
            wvalid = 1'b1;
            check("wready_fill", wready, (i < 8) ? 1 : 0);
            @(negedge clk);
        end
        wvalid = 1'b0;
        check("lvl_full", level, 8);
        check("wready_full", wready, 0);
        check("busy_disabled", busy, 0);
        check("irq_not_empty", irq_empty, 0);
        @(negedge clk);
        check("tx_idle_disabled", tx, 1);
        tx_en = 1'b1;
        @(negedge clk);
        check("lvl_first_start", level, 7);
        check("busy_drain", busy, 1);
        check("tx_latency_drain", tx, 1);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check("lvl_each_start", level, 7 - k);
            expect_frame(16'({1'b1, 8'(16 + k), 1'b0}), 10, 1);
        end
        check("tx_after_drain", tx, 1);
        check("busy_after_drain", busy, 0);
        check("lvl_after_drain", level, 0);
        check("irq_after_drain", irq_empty, 1);
        repeat (12) begin
            @(negedge clk);
            check("no_ninth_frame", tx, 1);
        end

        // Pause raised mid-DATA: current frame finishes, queued frame holds until release
        brr = 32'd2;
        push(9'h055);
        push(9'h066);
        check("lvl_pause_queue", level, 1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < 2; c++) begin
                check("pause_frame_bit", tx, 16'b000000_1_01010101_0 >> i & 16'd1);
                check("pause_ack_in_frame", pause_ack, 0);
                if (i == 4 && c == 0) pause_req = 1'b1;
                @(negedge clk);
            end
        end
        check("pause_ack_set", pause_ack, 1);
        check("busy_paused", busy, 0);
        check("tx_paused", tx, 1);
        check("lvl_paused", level, 1);
        check("wready_paused", wready, 0);
        wdata  = 9'h077;
        wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        check("lvl_push_refused", level, 1);
        repeat (4) begin
            @(negedge clk);
            check("hold_paused_busy", busy, 0);
            check("hold_paused_ack", pause_ack, 1);
            check("hold_paused_tx", tx, 1);
        end
        pause_req = 1'b0;
        @(negedge clk);
        check("pause_ack_drop", pause_ack, 0);
        check("busy_resume", busy, 1);
        check("lvl_resume", level, 0);
        check("tx_latency_resume", tx, 1);
        @(negedge clk);
        expect_frame(16'b000000_1_01100110_0, 10, 2);
        check("busy_after_resume", busy, 0);
        check("irq_after_resume", irq_empty, 1);

        // Reset pulse mid-DATA with three words queued
        push(9'h011);
        push(9'h022);
        push(9'h033);
        push(9'h044);
        check("lvl_before_rst", level, 3);
        @(negedge clk);
        check("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", tx, 1);
        check("midrst_level", level, 0);
        check("midrst_busy", busy, 0);
        check("midrst_wready", wready, 1);
        check("midrst_irq", irq_empty, 1);
        check("midrst_pause_ack", pause_ack, 0);
        repeat (25) begin
            @(negedge clk);
            check("no_frame_after_rst", {busy, tx}, 2'b01);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
